fp_div_seq: RTL

Multi-cycle IEEE-754 divider controller that sequences one division from start to done for half (binary16) or single (binary32) precision. Sign and exponent come from a front-end. Special operands are screened in a dedicated check state. The mantissa quotient is produced by a restoring shift-subtract loop at 1 bit/cycle, then normalized, rounded (round-to-nearest-even) and packed. It sits between the FPU issue logic and the result writeback, and exposes a start/busy/done handshake.

---
 rtl/fp_div_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 divider for binary16 / binary32.
// One division runs from an accepted start to a one-cycle done pulse.
// Special operands are resolved in CHECK. Finite quotients come from a
// restoring divider that produces 1 bit per cycle, followed by a single
// normalize/round/pack cycle. Rounding is round-to-nearest-even.
// Subnormal inputs are treated as zero, and underflowing results are
// flushed to zero.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start          request, sampled only while idle
//   MODE_FP        0 = half, 1 = single (latched at start)
//   OP_A, OP_B     dividend / divisor (half uses [15:0])
//   busy           high in CHECK, DIV and NORM
//   done           one-cycle pulse; result/flags valid
//   result         packed quotient (half zero-extended), held
//   flags          {invalid, div_by_zero, overflow, underflow, inexact}
module fp_div_seq #(
  parameter int SGL_QBITS = 26,
  parameter int HLF_QBITS = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        MODE_FP,
  input  logic [31:0] OP_A,
  input  logic [31:0] OP_B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  localparam int QW  = SGL_QBITS;
  localparam int HSH = SGL_QBITS - HLF_QBITS;

  typedef enum logic [2:0] {IDLE, CHECK, DIV, NORM, DONE} state_t;

  state_t             state;
  logic               mode_reg;
  logic [31:0]        a_reg, b_reg;
  logic signed [9:0]  exp_reg;
  logic [24:0]        rem_reg;
  logic [23:0]        div_reg;
  logic [QW-1:0]      q_reg;
  logic [4:0]         cnt_reg;

  // Operand unpack. Half mantissas are left-aligned into 23 bits, so a
  // single 24-bit divider datapath serves both formats.
  logic        sa, sb, sign;
  logic [7:0]  ea, eb, emax;
  logic [22:0] ma, mb;
  always_comb begin
    if (mode_reg) begin
      sa = a_reg[31]; ea = a_reg[30:23]; ma = a_reg[22:0];
      sb = b_reg[31]; eb = b_reg[30:23]; mb = b_reg[22:0];
      emax = 8'hFF;
    end else begin
      sa = a_reg[15]; ea = {3'b0, a_reg[14:10]}; ma = {a_reg[9:0], 13'b0};
      sb = b_reg[15]; eb = {3'b0, b_reg[14:10]}; mb = {b_reg[9:0], 13'b0};
      emax = 8'h1F;
    end
    sign = sa ^ sb;
  end

  // A zero exponent covers both zero and subnormals (treated as zero).
  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  assign nan_a  = (ea == emax) && (ma != 23'd0);
  assign nan_b  = (eb == emax) && (mb != 23'd0);
  assign inf_a  = (ea == emax) && (ma == 23'd0);
  assign inf_b  = (eb == emax) && (mb == 23'd0);
  assign zero_a = (ea == 8'd0);
  assign zero_b = (eb == 8'd0);

  logic [31:0] qnan_word, inf_word, zero_word;
  assign qnan_word = mode_reg ? 32'h7FC0_0000 : 32'h0000_7E00;
  assign inf_word  = mode_reg ? {sign, 8'hFF, 23'b0} : {16'b0, sign, 5'h1F, 10'b0};
  assign zero_word = mode_reg ? {sign, 31'b0} : {16'b0, sign, 15'b0};

  // Special-case screening, highest priority first.
  logic        special;
  logic [31:0] spec_result;
  logic [4:0]  spec_flags;
  always_comb begin
    special     = 1'b1;
    spec_result = 32'd0;
    spec_flags  = 5'd0;
    if (nan_a || nan_b) begin
      spec_result = qnan_word; spec_flags = 5'b10000;
    end else if ((inf_a && inf_b) || (zero_a && zero_b)) begin
      spec_result = qnan_word; spec_flags = 5'b10000;
    end else if (zero_b && !inf_a) begin
      spec_result = inf_word;  spec_flags = 5'b01000;
    end else if (inf_a) begin
      spec_result = inf_word;
    end else if (inf_b || zero_a) begin
      spec_result = zero_word;
    end else begin
      special = 1'b0;
    end
  end

  logic signed [9:0] bias, exp_init;
  assign bias     = mode_reg ? 10'sd127 : 10'sd15;
  assign exp_init = $signed({2'b0, ea}) - $signed({2'b0, eb}) + bias;

  // Normalize / round / pack. Half quotients are shifted up so both
  // formats share the same MSB position.
  logic [QW-1:0]     qa, qn;
  logic signed [9:0] en, ef, emax_s;
  logic [23:0]       sig, inc, sig_r;
  logic              g, st, lsb, rup, carry, inexact;
  logic [31:0]       norm_result;
  logic [4:0]        norm_flags;
  always_comb begin
    qa = mode_reg ? q_reg : {q_reg[HLF_QBITS-1:0], {HSH{1'b0}}};
    if (qa[QW-1]) begin
      qn = qa;
      en = exp_reg;
    end else begin
      qn = qa << 1;
      en = exp_reg - 10'sd1;
    end
    if (mode_reg) begin
      sig = qn[QW-1:2];
      g   = qn[1];
      st  = qn[0] | (rem_reg != 25'd0);
      lsb = qn[2];
      inc = 24'd1;
    end else begin
      sig = {qn[QW-1:QW-11], 13'b0};
      g   = qn[QW-12];
      st  = (|qn[QW-13:0]) | (rem_reg != 25'd0);
      lsb = qn[QW-11];
      inc = 24'h00_2000;
    end
    rup   = g & (st | lsb);
    sig_r = sig + (rup ? inc : 24'd0);
    // The significand is normalized, so losing the hidden bit means the
    // increment rippled all the way out: mantissa becomes 1.0, exp + 1.
    carry   = ~sig_r[23];
    ef      = carry ? en + 10'sd1 : en;
    inexact = g | st;
    emax_s  = $signed({2'b0, emax}) - 10'sd1;
    if (ef > emax_s) begin
      norm_result = inf_word;
      norm_flags  = 5'b00101;
    end else if (ef < 10'sd1) begin
      norm_result = zero_word;
      norm_flags  = 5'b00011;
    end else begin
      norm_result = mode_reg ? {sign, ef[7:0], sig_r[22:0]}
                             : {16'b0, sign, ef[4:0], sig_r[22:13]};
      norm_flags  = {4'b0, inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_reg <= 1'b0;
      a_reg    <= 32'd0;
      b_reg    <= 32'd0;
      exp_reg  <= 10'sd0;
      rem_reg  <= 25'd0;
      div_reg  <= 24'd0;
      q_reg    <= '0;
      cnt_reg  <= 5'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 32'd0;
      flags    <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= OP_A;
            b_reg    <= OP_B;
            mode_reg <= MODE_FP;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (special) begin
            result <= spec_result;
            flags  <= spec_flags;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            exp_reg <= exp_init;
            rem_reg <= {2'b01, ma};
            div_reg <= {1'b1, mb};
            q_reg   <= '0;
            cnt_reg <= mode_reg ? 5'(SGL_QBITS) : 5'(HLF_QBITS);
            state   <= DIV;
          end
        end
        DIV: begin
          if (rem_reg >= {1'b0, div_reg}) begin
            rem_reg <= (rem_reg - {1'b0, div_reg}) << 1;
            q_reg   <= {q_reg[QW-2:0], 1'b1};
          end else begin
            rem_reg <= rem_reg << 1;
            q_reg   <= {q_reg[QW-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg - 5'd1;
          if (cnt_reg == 5'd1) state <= NORM;
        end
        NORM: begin
          result <= norm_result;
          flags  <= norm_flags;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
